// File: rtl/cordic_vector.sv
// -----------------------------------------------------------------------------
// cordic_vector
// Iterative vectoring-mode CORDIC (rectangular -> polar). Each accepted (x,y)
// sample is pre-rotated into the right half-plane, then driven towards the
// positive x axis with one micro-rotation per clock. The accumulated angle is
// the phase, and the final x is the magnitude scaled by the CORDIC gain
// K ~ 1.64676, which is not compensated. One result every ITERATIONS+1 cycles.
//
// Parameters
//   XY_BITS     width of the signed x_i / y_i inputs
//   PH_BITS     phase width; 2^PH_BITS is 360 degrees, two's complement
//   ITERATIONS  number of micro-rotations, 1..PH_BITS-1
//
// Ports
//   clk_in     in   rising-edge clock
//   RST        in   asynchronous active-low reset
//   x_i, y_i   in   signed input sample (real / imaginary)
//   valid_in   in   sample valid, taken only while ready_out=1
//   ready_out  out  engine idle, a sample offered now is accepted
//   mag_o      out  unsigned magnitude (XY_BITS+2 bits, includes gain K)
//   phase_o    out  signed phase atan2(y,x)
//   valid_out  out  single-cycle pulse, mag_o/phase_o carry a new result
// -----------------------------------------------------------------------------
module cordic_vector #(
  parameter int XY_BITS    = 12,
  parameter int PH_BITS    = 32,
  parameter int ITERATIONS = 16
) (
  input  logic                      clk_in,
  input  logic                      RST,
  input  logic signed [XY_BITS-1:0] x_i,
  input  logic signed [XY_BITS-1:0] y_i,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [XY_BITS+1:0]        mag_o,
  output logic [PH_BITS-1:0]        phase_o,
  output logic                      valid_out
);

  // Integer part of the x/y datapath: two extra bits cover K*sqrt(2) growth
  // for every input, including the most negative corner.
  localparam int XW = XY_BITS + 2;
  // Fractional guard bits below the integer LSB. Without them the shifted
  // terms vanish in the late iterations, y freezes at 0 and the angle
  // accumulator keeps adding arctangents, which spoils the phase accuracy.
  localparam int GUARD = ITERATIONS + 4;
  localparam int DW    = XW + GUARD;
  localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(ITERATIONS - 1);
  localparam logic [PH_BITS-1:0]   QUARTER  = {2'b01, {(PH_BITS-2){1'b0}}};
  localparam logic signed [DW-1:0] HALF_LSB = DW'(1) << (GUARD - 1);

  // atan(2^-i) scaled to 2^32 per turn, rounded to nearest.
  function automatic logic [31:0] atan32(input int idx);
    case (idx)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      16:      return 32'h0000_28BE;
      17:      return 32'h0000_145F;
      18:      return 32'h0000_0A30;
      19:      return 32'h0000_0518;
      20:      return 32'h0000_028C;
      21:      return 32'h0000_0146;
      22:      return 32'h0000_00A3;
      23:      return 32'h0000_0051;
      24:      return 32'h0000_0029;
      25:      return 32'h0000_0014;
      26:      return 32'h0000_000A;
      27:      return 32'h0000_0005;
      28:      return 32'h0000_0003;
      29:      return 32'h0000_0001;
      30:      return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Rescale the 32-bit table to PH_BITS, rounding when narrowing. Wider
  // phase words are left-aligned and gain no extra table precision.
  function automatic logic [PH_BITS-1:0] atan_scaled(input int idx);
    logic [63:0] v;
    int          sh_r;
    int          sh_l;
    sh_r = (PH_BITS < 32) ? (32 - PH_BITS) : 0;
    sh_l = (PH_BITS > 32) ? (PH_BITS - 32) : 0;
    v    = {32'd0, atan32(idx)};
    v    = ((v + ((64'd1 << sh_r) >> 1)) >> sh_r) << sh_l;
    return v[PH_BITS-1:0];
  endfunction

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ITER = 1'b1
  } state_t;

  state_t                r_state;
  logic signed [DW-1:0]  r_x;
  logic signed [DW-1:0]  r_y;
  logic [PH_BITS-1:0]    r_z;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_zero;
  logic                  r_done;
  logic                  r_ready;
  logic                  r_valid;
  logic [XW-1:0]         r_mag;
  logic [PH_BITS-1:0]    r_phase;

  logic signed [DW-1:0]  w_x_in;
  logic signed [DW-1:0]  w_y_in;
  logic signed [DW-1:0]  w_x_pre;
  logic signed [DW-1:0]  w_y_pre;
  logic [PH_BITS-1:0]    w_z_pre;
  logic signed [DW-1:0]  w_x_sh;
  logic signed [DW-1:0]  w_y_sh;
  logic [PH_BITS-1:0]    w_atan_tab [ITERATIONS];
  logic [PH_BITS-1:0]    w_atan;

  genvar gi;
  generate
    for (gi = 0; gi < ITERATIONS; gi++) begin : g_atan
      assign w_atan_tab[gi] = atan_scaled(gi);
    end
  endgenerate

  assign w_atan = w_atan_tab[r_cnt];

  // Sign-extend to the integer width, then place above the guard bits.
  assign w_x_in = {{2{x_i[XY_BITS-1]}}, x_i, {GUARD{1'b0}}};
  assign w_y_in = {{2{y_i[XY_BITS-1]}}, y_i, {GUARD{1'b0}}};

  // Fold the left half-plane by +/-90 degrees so the iterations only need
  // to cover the +/-90 degree range around the positive x axis.
  always_comb begin
    w_x_pre = w_x_in;
    w_y_pre = w_y_in;
    w_z_pre = '0;
    if (x_i[XY_BITS-1]) begin
      if (!y_i[XY_BITS-1]) begin
        w_x_pre = w_y_in;
        w_y_pre = -w_x_in;
        w_z_pre = QUARTER;
      end else begin
        w_x_pre = -w_y_in;
        w_y_pre = w_x_in;
        w_z_pre = -QUARTER;
      end
    end
  end

  assign w_x_sh = r_x >>> r_cnt;
  assign w_y_sh = r_y >>> r_cnt;

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_mag   <= '0;
      r_phase <= '0;
    end else begin
      r_valid <= 1'b0;

      // Output stage: registers the finished rotation one edge after the
      // last iteration. It reads the pre-edge x/z, so a new sample accepted
      // on this same edge does not disturb the result.
      if (r_done) begin
        r_done  <= 1'b0;
        r_valid <= 1'b1;
        if (r_zero) begin
          r_mag   <= '0;
          r_phase <= '0;
        end else begin
          // Round the guarded x back to an integer magnitude.
          r_mag   <= XW'((r_x + HALF_LSB) >>> GUARD);
          r_phase <= r_z;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (valid_in && r_ready) begin
            r_x     <= w_x_pre;
            r_y     <= w_y_pre;
            r_z     <= w_z_pre;
            r_zero  <= (x_i == '0) && (y_i == '0);
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          // Rotate towards y=0: clockwise while y is non-negative.
          if (!r_y[DW-1]) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
          end
          if (r_cnt == LAST_CNT) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_out = r_ready;
  assign valid_out = r_valid;
  assign mag_o     = r_mag;
  assign phase_o   = r_phase;

endmodule

// File: tb/tb_cordic_vector.sv
// -----------------------------------------------------------------------------
// tb_cordic_vector
// Self-checking bench for cordic_vector (XY_BITS=12, PH_BITS=32,
// ITERATIONS=16). Every accepted sample is modelled with real-valued
// atan2/sqrt and queued; each valid_out pulse is checked against the queue
// head for latency, magnitude and phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cordic_vector;

  localparam int     XY_BITS    = 12;
  localparam int     PH_BITS    = 32;
  localparam int     ITERATIONS = 16;
  localparam longint LATENCY    = ITERATIONS + 1;
  localparam longint MAG_TOL    = 2;
  localparam longint PH_TOL     = 65536;
  localparam real    K_GAIN     = 1.6467602581;
  localparam real    TWO_PI     = 6.283185307179586;
  localparam int     N_RANDOM   = 1500;

  logic                      clk_in = 1'b0;
  logic                      RST    = 1'b1;
  logic signed [XY_BITS-1:0] x_i    = '0;
  logic signed [XY_BITS-1:0] y_i    = '0;
  logic                      valid_in = 1'b0;
  logic                      ready_out;
  logic [XY_BITS+1:0]        mag_o;
  logic [PH_BITS-1:0]        phase_o;
  logic                      valid_out;

  cordic_vector #(
    .XY_BITS   (XY_BITS),
    .PH_BITS   (PH_BITS),
    .ITERATIONS(ITERATIONS)
  ) dut (
    .clk_in   (clk_in),
    .RST      (RST),
    .x_i      (x_i),
    .y_i      (y_i),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .mag_o    (mag_o),
    .phase_o  (phase_o),
    .valid_out(valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int     x;
    int     y;
    bit     zero;
    longint mag;
    longint ph;
    longint acc_cycle;
  } exp_t;

  exp_t   exp_q[$];
  int     n_total    = 0;
  int     n_bad      = 0;
  int     n_results  = 0;
  int     n_accepts  = 0;
  longint cycle      = 0;
  logic   prev_valid = 1'b0;

  task automatic check_val(input string tag, input longint got, input longint want,
                           input longint tol);
    longint d;
    d = got - want;
    n_total++;
    if (d > tol || d < -tol) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d tol=%0d", tag, got, want, tol);
    end
  endtask

  // Ideal polar conversion of one sample.
  function automatic exp_t model(input int x, input int y, input longint cyc);
    exp_t e;
    real  r;
    real  a;
    e.x         = x;
    e.y         = y;
    e.acc_cycle = cyc;
    e.zero      = (x == 0) && (y == 0);
    if (e.zero) begin
      e.mag = 0;
      e.ph  = 0;
    end else begin
      r     = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      e.mag = longint'($floor(K_GAIN * r + 0.5));
      a     = $atan2(real'(y), real'(x));
      e.ph  = longint'($floor(a / TWO_PI * 4294967296.0 + 0.5));
    end
    return e;
  endfunction

  initial begin : cycle_counter
    forever begin
      @(posedge clk_in);
      cycle++;
    end
  end

  // Monitor: observes at the falling edge, away from the DUT's active edge.
  initial begin : monitor
    exp_t        e;
    logic [31:0] w32;
    longint      near;
    forever begin
      @(negedge clk_in);
      if (!RST) begin
        exp_q.delete();
        prev_valid = 1'b0;
      end else begin
        if (valid_out) begin
          n_results++;
          check_val("pulse_width", longint'(prev_valid), 0, 0);
          if (exp_q.size() == 0) begin
            check_val("spurious_valid", longint'(valid_out), 0, 0);
          end else begin
            e = exp_q.pop_front();
            check_val("latency", cycle - e.acc_cycle - 1, LATENCY, 0);
            check_val("mag", longint'(mag_o), e.mag, e.zero ? 0 : MAG_TOL);
            // Express the DUT phase as the value nearest the model, so that
            // +180 and -180 degrees compare as equal.
            w32  = phase_o - e.ph[31:0];
            near = e.ph + longint'($signed(w32));
            check_val("phase", near, e.ph, e.zero ? 0 : PH_TOL);
            $display("result x=%0d y=%0d mag=%0d (model %0d) phase=%08h (model %08h)",
                     e.x, e.y, mag_o, e.mag, phase_o, e.ph[31:0]);
          end
        end
        prev_valid = valid_out;
        if (ready_out && valid_in) begin
          exp_q.push_back(model(int'(x_i), int'(y_i), cycle));
          n_accepts++;
        end
      end
    end
  end

  // Caller is at posedge+1. Offers one sample once the engine is ready.
  task automatic send(input int x, input int y);
    int waited;
    waited = 0;
    while (!ready_out && waited < 100) begin
      @(posedge clk_in);
      #1;
      waited++;
    end
    if (!ready_out) check_val("ready_timeout", longint'(ready_out), 1, 0);
    x_i      = x[XY_BITS-1:0];
    y_i      = y[XY_BITS-1:0];
    valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_in);
      n++;
    end
    if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 0, 0);
    @(posedge clk_in);
    #1;
  endtask

  int dir_x [9] = '{1000, 0,    0,     -1000, -2048, 0, 2047, -2048, -1};
  int dir_y [9] = '{0,    1000, -1000, 0,     -2048, 0, 2047, 2047,  -1};

  initial begin : stimulus
    int acc0;
    int res0;
    #2;
    RST = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_val("rst_ready", longint'(ready_out), 1, 0);
    check_val("rst_valid", longint'(valid_out), 0, 0);
    check_val("rst_mag",   longint'(mag_o), 0, 0);
    check_val("rst_phase", longint'(phase_o), 0, 0);
    RST = 1'b1;
    @(posedge clk_in);
    #1;

    // Directed points, including quadrant folds, the negative corner and zero.
    for (int i = 0; i < 9; i++) begin
      send(dir_x[i], dir_y[i]);
      drain();
    end

    // valid_in held high with a new sample every cycle: only samples offered
    // while ready_out=1 are taken, one per ITERATIONS+1 cycles.
    acc0 = n_accepts;
    for (int c = 0; c < 60; c++) begin
      x_i      = 12'($urandom_range(4095, 0));
      y_i      = 12'($urandom_range(4095, 0));
      valid_in = 1'b1;
      @(posedge clk_in);
      #1;
    end
    valid_in = 1'b0;
    check_val("stream_accepts", n_accepts - acc0, 4, 0);
    drain();

    // Abort mid-computation with reset.
    send(1000, 0);
    repeat (8) @(posedge clk_in);
    #3;
    res0 = n_results;
    RST  = 1'b0;
    #1;
    check_val("abort_ready", longint'(ready_out), 1, 0);
    check_val("abort_valid", longint'(valid_out), 0, 0);
    check_val("abort_mag",   longint'(mag_o), 0, 0);
    check_val("abort_phase", longint'(phase_o), 0, 0);
    repeat (2) @(posedge clk_in);
    #1;
    RST = 1'b1;
    repeat (25) @(posedge clk_in);
    #1;
    check_val("abort_no_result", n_results - res0, 0, 0);
    send(1000, 0);
    drain();

    // Random sweep against the real-math model.
    for (int i = 0; i < N_RANDOM; i++) begin
      send(int'($urandom_range(4095, 0)) - 2048, int'($urandom_range(4095, 0)) - 2048);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    check_val("watchdog_cycles", cycle, 0, 80000);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
